// File: rtl/shake_port_arbiter.sv
// shake_port_arbiter
//   Shares one W-bit word-stream sink between two producers. Each producer
//   posts a header (packet length in words), then streams exactly that many
//   words. The grant is held until the final word transfers, so packets never
//   interleave. Arbitration between simultaneous headers is round-robin.
//   Data handshakes are combinational pass-through (zero latency).
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   reqN_len/isReady/canReceive   header channel of requester N (N = 0, 1)
//   inN/inN_isReady/canReceive    data channel of requester N
//   out/out_isReady/out_canReceive granted data stream toward the sink
//   out_last                      current out word ends its packet
//   out_src                       current grant holder (0 when idle)
//   busy                          a packet is in flight
module shake_port_arbiter #(
  parameter int W     = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             req0_isReady,
  output logic             req0_canReceive,
  input  logic [W-1:0]     in0,
  input  logic             in0_isReady,
  output logic             in0_canReceive,
  input  logic [LEN_W-1:0] req1_len,
  input  logic             req1_isReady,
  output logic             req1_canReceive,
  input  logic [W-1:0]     in1,
  input  logic             in1_isReady,
  output logic             in1_canReceive,
  output logic [W-1:0]     out,
  output logic             out_isReady,
  input  logic             out_canReceive,
  output logic             out_last,
  output logic             out_src,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state_reg;
  logic             grant_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             last_grant_reg;

  // Per-requester views so the two ports can be handled uniformly.
  logic [1:0]       hdr_valid;
  logic [1:0]       hdr_ready;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [LEN_W-1:0] len_sel  [2];
  logic [W-1:0]     word_sel [2];

  logic             idle;
  logic             xfer;
  logic             winner;
  logic             hdr_fire;
  logic             data_fire;
  logic             last_word;
  logic [LEN_W-1:0] win_len;

  assign hdr_valid   = {req1_isReady, req0_isReady};
  assign in_valid    = {in1_isReady, in0_isReady};
  assign len_sel[0]  = req0_len;
  assign len_sel[1]  = req1_len;
  assign word_sel[0] = in0;
  assign word_sel[1] = in1;

  // Every output is gated by rst so that nothing is offered or accepted
  // while reset is held, even before the first reset edge has landed.
  assign idle = rst & (state_reg == IDLE);
  assign xfer = rst & (state_reg == XFER);

  // On a tie the requester that did not win last time takes the grant.
  assign winner = (&hdr_valid) ? ~last_grant_reg : hdr_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign hdr_ready[gi] = idle & hdr_valid[gi] & (winner == 1'(gi));
      assign in_ready[gi]  = xfer & (grant_reg == 1'(gi)) & out_canReceive;
    end
  endgenerate

  assign req0_canReceive = hdr_ready[0];
  assign req1_canReceive = hdr_ready[1];
  assign in0_canReceive  = in_ready[0];
  assign in1_canReceive  = in_ready[1];

  // hdr_ready already includes isReady, so any set bit is an accepted header.
  assign hdr_fire = |hdr_ready;
  assign win_len  = len_sel[winner];

  assign out_isReady = xfer & in_valid[grant_reg];
  assign out         = out_isReady ? word_sel[grant_reg] : '0;
  assign data_fire   = out_isReady & out_canReceive;
  assign last_word   = (cnt_reg == LEN_W'(1));
  assign out_last    = xfer & last_word;
  assign out_src     = xfer & grant_reg;
  assign busy        = xfer;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;   // requester 0 wins the first tie
    end else begin
      case (state_reg)
        IDLE: begin
          if (hdr_fire) begin
            if (win_len != '0) begin
              state_reg <= XFER;
              grant_reg <= winner;
              cnt_reg   <= win_len;
            end else begin
              // Empty packet: consumed in place, but it still counts as a
              // grant for fairness purposes.
              last_grant_reg <= winner;
            end
          end
        end
        XFER: begin
          if (data_fire) begin
            cnt_reg <= cnt_reg - LEN_W'(1);
            if (last_word) begin
              state_reg      <= IDLE;
              last_grant_reg <= grant_reg;
            end
          end
        end
      endcase
    end
  end

endmodule
